muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits; all values below are for WIDTH=32.

Ports (name  direction  width  meaning)
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 The block SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports a and b  input  WIDTH  operands rs1 and rs2, sampled with start.
REQ-007 The block SHALL have port flush  input  1  abort of the current operation.
REQ-008 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 The block SHALL have port result  output  WIDTH  holds its value from done until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, PREP, CALC, FIN.
REQ-012 In IDLE with start=1 and flush=0, the block SHALL latch funct3, a and b and go to PREP; start outside IDLE SHALL be ignored.
REQ-013 PREP SHALL take 1 cycle:
- convert signed operands to magnitudes per funct3 (MULHSU: a signed, b unsigned);
- record result sign;
- load iteration counter = 0;
- go to CALC, or to FIN directly for a special case (REQ-016, REQ-017).
REQ-014 CALC SHALL take exactly 32 cycles, one iteration per cycle, then go to FIN:
- multiply: radix-2 shift-add into a 64-bit unsigned product;
- divide: restoring shift-subtract giving 32-bit quotient and remainder;
- counter 0..31; leave CALC when counter=31.
REQ-015 FIN SHALL take 1 cycle and then return to IDLE:
- apply the sign: product two's-complement negated as 64 bits; quotient negated if operand signs differ; remainder takes dividend sign;
- select result: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder;
- register result; assert done for exactly this cycle.
REQ-016 Divide by zero (b=0, funct3 1xx) SHALL give quotient 0xFFFFFFFF and remainder = a, via PREP->FIN.
REQ-017 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0, via PREP->FIN.
REQ-018 Latency, with start sampled at edge 0:
- normal op: done high in the cycle after edge 34;
- special case: done high in the cycle after edge 2;
- busy high from edge 1 until the edge that returns to IDLE.
REQ-019 flush in any state SHALL force IDLE at the next edge, with no done pulse and result unchanged.
- flush and start together in IDLE: start is ignored.
- flush in FIN: the done pulse of that cycle still occurs; FIN returns to IDLE anyway.
REQ-020 A new start SHALL be accepted no earlier than the cycle after FIN, i.e. when busy=0; there is no back-to-back overlap.
REQ-021 All arithmetic SHALL be unsigned internally, with sign fixed only in PREP and FIN; no X propagation from unused operand bits.

Reset
REQ-022 rst_n=0 SHALL immediately, without clk, force: state IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
REQ-023 Assertion of rst_n mid-operation SHALL abort the operation with no done pulse, and the first start after release SHALL complete normally.

Verification
REQ-024 The bench SHALL cover each of these directed scenarios:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at edge 34, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU a=0x1234, b=0 -> result 0xFFFFFFFF at edge 2; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at edge 2.
- start pulsed again at edges 5 and 20 during an op -> ignored, single done at edge 34, result of the first op.
- flush at edge 10 -> busy=0 at edge 11, no done, previous result retained; new start at edge 12 -> correct result at edge 46.
- rst_n low at edge 15 of a MULHSU -> outputs 0 asynchronously; after release, MULHSU a=-1, b=2 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_sequencer                                           |
// | Description : Sequential RV32M multiply/divide unit. Operands are        |
// |               turned into magnitudes, iterated one bit per cycle         |
// |               (shift-add multiply or restoring divide), then the sign    |
// |               is applied and the requested half/quotient/remainder is    |
// |               registered onto the result output.                         |
// | Ports       : clk     - clock, rising edge                               |
// |               rst_n   - asynchronous active-low reset                    |
// |               start   - operation request, taken only when idle          |
// |               funct3  - RV32M op (MUL..REMU)                             |
// |               a, b    - operands rs1 / rs2, captured with start          |
// |               flush   - abort the operation in progress                  |
// |               busy    - unit is not idle                                 |
// |               done    - one-cycle pulse, result valid                    |
// |               result  - last completed result, held until next start     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int                   CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]     c_CNT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]     c_ZERO      = '0;
   localparam logic [WIDTH-1:0]     c_ALL_ONES  = '1;
   localparam logic [WIDTH-1:0]     c_MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2*WIDTH-1:0]   c_ZERO2     = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      CALC = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   // hi/lo: product {hi,lo} for multiply; remainder (hi) and
   // dividend-shifting-into-quotient (lo) for divide.
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   // Multiplicand magnitude or divisor magnitude.
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;     // negate product / quotient
   logic               rneg_q, rneg_d;   // negate remainder
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   // ---------------------------------------------------------------------
   // Operand signedness and magnitudes (valid while in PREP)
   // ---------------------------------------------------------------------
   logic               w_a_signed, w_b_signed;
   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic               w_div_zero, w_div_ovf;

   // a is signed for MUL, MULH, MULHSU, DIV, REM; b for MUL, MULH, DIV, REM.
   assign w_a_signed = op_q[2] ? ~op_q[0] : ~(op_q[1] & op_q[0]);
   assign w_b_signed = op_q[2] ? ~op_q[0] : ~op_q[1];
   assign w_a_neg    = w_a_signed & a_q[WIDTH-1];
   assign w_b_neg    = w_b_signed & b_q[WIDTH-1];
   assign w_mag_a    = w_a_neg ? (c_ZERO - a_q) : a_q;
   assign w_mag_b    = w_b_neg ? (c_ZERO - b_q) : b_q;
   assign w_div_zero = op_q[2] & (b_q == c_ZERO);
   assign w_div_ovf  = op_q[2] & ~op_q[0] & (a_q == c_MIN_NEG) & (b_q == c_ALL_ONES);

   // ---------------------------------------------------------------------
   // One iteration of each algorithm
   // ---------------------------------------------------------------------
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_rem_shift;
   logic               w_fits;

   // Shift-add: add multiplicand into the upper half when the current
   // multiplier bit (lo[0]) is set, then shift the 2W+1-bit value right.
   assign w_mul_sum   = {1'b0, hi_q} + {1'b0, dvs_q & {WIDTH{lo_q[0]}}};
   // Restoring divide: bring the next dividend bit into the remainder.
   assign w_rem_shift = {hi_q, lo_q[WIDTH-1]};
   assign w_fits      = (w_rem_shift >= {1'b0, dvs_q});

   // ---------------------------------------------------------------------
   // Sign application and result selection (valid while in FIN)
   // ---------------------------------------------------------------------
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH-1:0]   w_quot, w_rem, w_final;

   assign w_prod     = {hi_q, lo_q};
   assign w_prod_fix = neg_q ? (c_ZERO2 - w_prod) : w_prod;
   assign w_quot     = neg_q ? (c_ZERO - lo_q) : lo_q;
   assign w_rem      = rneg_q ? (c_ZERO - hi_q) : hi_q;

   always_comb begin
      w_final = w_rem;
      case (op_q)
         3'b000:                 w_final = w_prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         w_final = w_quot;
         default:                w_final = w_rem;
      endcase
   end

   // ---------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      done_d   = 1'b0;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d    = funct3;
               a_d     = a;
               b_d     = b;
               state_d = PREP;
            end
         end

         PREP: begin
            cnt_d  = '0;
            hi_d   = c_ZERO;
            neg_d  = w_a_neg ^ w_b_neg;
            rneg_d = w_a_neg;
            if (op_q[2]) begin
               lo_d  = w_mag_a;
               dvs_d = w_mag_b;
            end else begin
               lo_d  = w_mag_b;
               dvs_d = w_mag_a;
            end
            state_d = CALC;
            // Special divide cases load their final quotient/remainder
            // unsigned and skip the iteration entirely.
            if (w_div_zero) begin
               lo_d    = c_ALL_ONES;
               hi_d    = a_q;
               neg_d   = 1'b0;
               rneg_d  = 1'b0;
               state_d = FIN;
            end else if (w_div_ovf) begin
               lo_d    = c_MIN_NEG;
               hi_d    = c_ZERO;
               neg_d   = 1'b0;
               rneg_d  = 1'b0;
               state_d = FIN;
            end
         end

         CALC: begin
            if (op_q[2]) begin
               hi_d = w_fits ? (w_rem_shift[WIDTH-1:0] - dvs_q) : w_rem_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], w_fits};
            end else begin
               hi_d = w_mul_sum[WIDTH:1];
               lo_d = {w_mul_sum[0], lo_q[WIDTH-1:1]};
            end
            if (cnt_q == c_CNT_LAST) begin
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         FIN: begin
            result_d = w_final;
            done_d   = 1'b1;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // A flush in FIN is too late to suppress the completion.
      if (flush && (state_q != FIN)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= 3'b000;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_muldiv_sequencer                                        |
// | Description : Directed-vector bench for muldiv_sequencer. Stimulus       |
// |               pushes the expected result and completion edge into a      |
// |               queue; a monitor pops and compares on every done pulse.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_muldiv_sequencer;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic        flush  = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] a      = 32'd0;
   logic [31:0] b      = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int cyc    = 0;
   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [31:0] res;
      int          edge_no;
      string       name;
   } exp_t;

   exp_t sb[$];

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen at a negedge is the number of the preceding posedge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: result=%h at edge %0d, expected no done", result, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " result"}, result, e.res);
            check({e.name, " done_edge"}, 32'(cyc), 32'(e.edge_no));
         end
      end
   end

   // Drive one start pulse; e is the number of the edge that samples it.
   task automatic drive(input logic [2:0] f, input logic [31:0] ia, input logic [31:0] ib,
                        output int e);
      @(negedge clk);
      funct3 = f;
      a      = ia;
      b      = ib;
      start  = 1'b1;
      e      = cyc + 1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic push(input string name, input logic [31:0] res, input int edge_no);
      exp_t e;
      e.res     = res;
      e.edge_no = edge_no;
      e.name    = name;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         $display("FAIL %s timeout: busy=1 after %0d cycles, expected 0", name, n);
      end
      @(negedge clk);
      check({name, " done_pulse"}, {31'b0, done}, 32'd0);
      check({name, " sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] exp, input int lat);
      int e;
      drive(f, ia, ib, e);
      push(name, exp, e + lat);
      check({name, " busy"}, {31'b0, busy}, 32'd1);
      wait_idle(name);
   endtask

   initial begin
      int e;
      #1;
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal operations (34-edge latency)
      run_op("mul",       F_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      run_op("mulh",      F_MULH,   32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 34);
      run_op("mulhu",     F_MULHU,  32'd7,          32'hFFFFFFFD, 32'h00000006, 34);
      run_op("mulhu_max", F_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      run_op("mul_max",   F_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 34);
      run_op("div",       F_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34);
      run_op("rem",       F_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34);
      run_op("div_nn",    F_DIV,    32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        34);
      run_op("divu",      F_DIVU,   32'd100,        32'd7,        32'd14,       34);
      run_op("remu",      F_REMU,   32'd100,        32'd7,        32'd2,        34);
      run_op("remu_small",F_REMU,   32'd7,          32'd100,      32'd7,        34);
      run_op("divu_by1",  F_DIVU,   32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 34);

      // Special cases (2-edge latency)
      run_op("divu_zero", F_DIVU,   32'h00001234,   32'd0,        32'hFFFFFFFF, 2);
      run_op("rem_zero",  F_REM,    32'h00001234,   32'd0,        32'h00001234, 2);
      run_op("div_ovf",   F_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2);
      run_op("rem_ovf",   F_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 2);

      // start while busy is ignored
      drive(F_MUL, 32'd7, 32'hFFFFFFFD, e);
      push("ignore_start", 32'hFFFFFFEB, e + 34);
      while (cyc != e + 4) @(negedge clk);
      funct3 = F_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc != e + 19) @(negedge clk);
      funct3 = F_REMU; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("ignore_start");

      // flush mid-operation: no done, result retained
      drive(F_DIVU, 32'd100, 32'd7, e);
      while (cyc != e + 9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", {31'b0, busy}, 32'd0);
      check("flush result_held", result, 32'hFFFFFFEB);
      run_op("after_flush", F_DIVU, 32'd100, 32'd7, 32'd14, 34);

      // flush in FIN still completes
      drive(F_DIVU, 32'h00000055, 32'd0, e);
      push("flush_fin", 32'hFFFFFFFF, e + 2);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_fin busy", {31'b0, busy}, 32'd0);
      wait_idle("flush_fin");

      // start together with flush in IDLE is ignored
      @(negedge clk);
      funct3 = F_MUL; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("start_flush busy", {31'b0, busy}, 32'd0);
      check("start_flush result", result, 32'hFFFFFFFF);
      wait_idle("start_flush");

      // asynchronous reset mid-operation
      drive(F_MULHSU, 32'd5, 32'd3, e);
      while (cyc != e + 14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("areset busy", {31'b0, busy}, 32'd0);
      check("areset done", {31'b0, done}, 32'd0);
      check("areset result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);

      repeat (5) @(negedge clk);
      check("final sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
